// File: rtl/fetch_ctrl_pkg.sv
// Shared constants, FSM encodings and the fetched-word record for the
// instruction fetch controller.
package fetch_ctrl_pkg;

   localparam logic RST_ENABLE    = 1'b0;
   localparam logic NO_STOP       = 1'b0;
   localparam logic BRANCH_ENABLE = 1'b1;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;

   localparam logic [INST_W-1:0] ZERO_WORD = '0;

   localparam logic [1:0] FC_BOOT = 2'd0;
   localparam logic [1:0] FC_REQ  = 2'd1;
   localparam logic [1:0] FC_WAIT = 2'd2;
   localparam logic [1:0] FC_HOLD = 2'd3;

   typedef struct packed {
      logic [INST_W-1:0]      inst;
      logic [INST_ADDR_W-1:0] addr;
   } fetch_word_t;

endpackage

// File: rtl/fetch_buf.sv
// Output register toward IF/ID plus a one-entry skid that catches a response
// arriving while the output is full and stalled.
module fetch_buf
   import fetch_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        load_out,
   input  logic        load_skid,
   input  logic        pop_skid,
   input  logic        stall_id,
   input  fetch_word_t wr_word,
   output logic        out_valid,
   output fetch_word_t out_word
);

   logic        skid_valid;
   fetch_word_t skid_word;

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         out_word   <= '{inst: ZERO_WORD, addr: ZERO_WORD};
         skid_word  <= '{inst: ZERO_WORD, addr: ZERO_WORD};
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (pop_skid) begin
         out_word   <= skid_word;
         out_valid  <= skid_valid;
         skid_valid <= 1'b0;
      end else begin
         // A word is consumed whenever it is shown with IF/ID not stalled.
         if (load_out) begin
            out_word  <= wr_word;
            out_valid <= 1'b1;
         end else if (!stall_id) begin
            out_valid <= 1'b0;
         end
         if (load_skid) begin
            skid_word  <= wr_word;
            skid_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: boot delay, single-outstanding bus fetch,
// branch kill of in-flight responses and sticky response timeout.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int BOOT_DELAY = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INST_ADDR_W-1:0] pc_i,
   input  logic                   branch_flag_i,
   input  logic [5:0]             stalled,
   output logic                   ibus_req_o,
   output logic [INST_ADDR_W-1:0] ibus_addr_o,
   input  logic                   ibus_gnt_i,
   input  logic                   ibus_rvalid_i,
   input  logic [INST_W-1:0]      ibus_rdata_i,
   output logic                   pc_change_en_o,
   output logic [INST_W-1:0]      inst_o,
   output logic [INST_ADDR_W-1:0] inst_addr_o,
   output logic                   inst_valid_o,
   output logic                   fetch_err_o
);

   localparam int CNT_MAX = (BOOT_DELAY > TIMEOUT) ? BOOT_DELAY : TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_DELAY - 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

   logic [1:0]             state;
   logic [CW-1:0]          cnt;
   logic                   kill;
   logic                   err;
   logic [INST_ADDR_W-1:0] pend_addr;
   logic                   out_valid;
   fetch_word_t            out_word;
   fetch_word_t            wr_word;

   logic branch, stall_pc, stall_id, grant;
   logic resp_ok, load_out, load_skid, pop_skid, flush;
   logic unused_stall;

   assign branch   = (branch_flag_i == BRANCH_ENABLE);
   assign stall_pc = (stalled[0] != NO_STOP);
   assign stall_id = (stalled[1] != NO_STOP);
   assign unused_stall = ^stalled[5:2];

   assign ibus_req_o     = (state == FC_REQ) & !stall_pc & !branch & (!out_valid | !stall_id);
   assign ibus_addr_o    = pc_i;
   assign grant          = ibus_req_o & ibus_gnt_i;
   assign pc_change_en_o = grant;

   // Branch in the response cycle discards that response along with the buffers.
   assign resp_ok   = (state == FC_WAIT) & ibus_rvalid_i & !kill & !branch;
   assign load_out  = resp_ok & (!out_valid | !stall_id);
   assign load_skid = resp_ok & out_valid & stall_id;
   assign pop_skid  = (state == FC_HOLD) & !stall_id & !branch;
   assign flush     = branch & (state != FC_BOOT);
   assign wr_word   = '{inst: ibus_rdata_i, addr: pend_addr};

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         state     <= FC_BOOT;
         cnt       <= '0;
         kill      <= 1'b0;
         err       <= 1'b0;
         pend_addr <= '0;
      end else begin
         case (state)
            FC_BOOT: begin
               if (cnt == BOOT_LAST) begin
                  state <= FC_REQ;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            FC_REQ: begin
               // A late response owed to a timed-out fetch retires the kill here.
               if (ibus_rvalid_i) kill <= 1'b0;
               if (grant) begin
                  pend_addr <= pc_i;
                  cnt       <= '0;
                  state     <= FC_WAIT;
               end
            end
            FC_WAIT: begin
               if (ibus_rvalid_i) begin
                  kill  <= 1'b0;
                  state <= load_skid ? FC_HOLD : FC_REQ;
               end else begin
                  if (branch) kill <= 1'b1;
                  if (cnt == WAIT_LAST) begin
                     err   <= 1'b1;
                     kill  <= 1'b1;
                     state <= FC_REQ;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            FC_HOLD: begin
               if (branch || !stall_id) state <= FC_REQ;
            end
            default: state <= FC_BOOT;
         endcase
      end
   end

   fetch_buf u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .load_out  (load_out),
      .load_skid (load_skid),
      .pop_skid  (pop_skid),
      .stall_id  (stall_id),
      .wr_word   (wr_word),
      .out_valid (out_valid),
      .out_word  (out_word)
   );

   assign inst_valid_o = out_valid;
   assign inst_o       = out_word.inst;
   assign inst_addr_o  = out_word.addr;
   assign fetch_err_o  = err;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: queue-based reference model checked every cycle,
// a directed prologue with literal expectations, then randomized traffic.
module tb_fetch_ctrl;

   localparam int BD = 4;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_i = '0;
   logic        branch_flag_i = 1'b0;
   logic [5:0]  stalled = '0;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i = 1'b0;
   logic        ibus_rvalid_i = 1'b0;
   logic [31:0] ibus_rdata_i = '0;
   logic        pc_change_en_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        inst_valid_o;
   logic        fetch_err_o;
   logic [31:0] br_target = '0;

   always #5 clk = ~clk;

   fetch_ctrl #(.BOOT_DELAY(BD), .TIMEOUT(TO)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_i           (pc_i),
      .branch_flag_i  (branch_flag_i),
      .stalled        (stalled),
      .ibus_req_o     (ibus_req_o),
      .ibus_addr_o    (ibus_addr_o),
      .ibus_gnt_i     (ibus_gnt_i),
      .ibus_rvalid_i  (ibus_rvalid_i),
      .ibus_rdata_i   (ibus_rdata_i),
      .pc_change_en_o (pc_change_en_o),
      .inst_o         (inst_o),
      .inst_addr_o    (inst_addr_o),
      .inst_valid_o   (inst_valid_o),
      .fetch_err_o    (fetch_err_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: delivered words waiting for IF/ID form a queue (front is visible).
   typedef struct {
      logic [31:0] inst;
      logic [31:0] addr;
   } word_t;

   word_t       mq[$];
   int          boot_left = BD;
   bit          m_out = 0;
   bit          m_drop = 0;
   bit          m_err = 0;
   bit          m_last_grant = 0;
   int          m_waited = 0;
   logic [31:0] m_pend = '0;
   logic [31:0] m_next_pc = '0;

   function automatic bit exp_req();
      return rst && boot_left == 0 && !m_out && mq.size() < 2 && !stalled[0] &&
             !branch_flag_i && (mq.size() == 0 || !stalled[1]);
   endfunction

   always @(posedge clk) begin : model
      bit    grant;
      bit    accept;
      word_t w;
      grant  = 0;
      accept = 0;
      if (!rst) begin
         boot_left = BD; m_out = 0; m_drop = 0; m_err = 0; m_waited = 0;
         m_last_grant = 0; m_next_pc = '0;
         mq.delete();
      end else begin
         grant = exp_req() && ibus_gnt_i;
         m_next_pc = branch_flag_i ? br_target : (grant ? pc_i + 32'd4 : pc_i);
         if (boot_left > 0) begin
            boot_left--;
         end else begin
            if (m_out) begin
               if (ibus_rvalid_i) begin
                  accept = !m_drop && !branch_flag_i;
                  m_drop = 0;
                  m_out  = 0;
               end else begin
                  if (branch_flag_i) m_drop = 1;
                  if (m_waited == TO - 1) begin
                     m_err = 1; m_drop = 1; m_out = 0;
                  end else begin
                     m_waited++;
                  end
               end
            end else if (ibus_rvalid_i && m_drop) begin
               m_drop = 0;
            end
            if (branch_flag_i) begin
               mq.delete();
            end else begin
               if (mq.size() > 0 && !stalled[1]) void'(mq.pop_front());
               if (accept) begin
                  w.inst = ibus_rdata_i;
                  w.addr = m_pend;
                  mq.push_back(w);
               end
            end
            if (grant) begin
               m_out = 1; m_pend = pc_i; m_waited = 0;
            end
         end
         m_last_grant = grant;
      end
   end

   always @(negedge clk) begin : compare
      bit r;
      if (!rst) begin
         check("rst_req",   32'(ibus_req_o),     32'd0);
         check("rst_pcc",   32'(pc_change_en_o), 32'd0);
         check("rst_valid", 32'(inst_valid_o),   32'd0);
         check("rst_inst",  inst_o,              32'd0);
         check("rst_iaddr", inst_addr_o,         32'd0);
         check("rst_err",   32'(fetch_err_o),    32'd0);
      end else begin
         r = exp_req();
         check("req", 32'(ibus_req_o), 32'(r));
         check("pcc", 32'(pc_change_en_o), 32'(r && ibus_gnt_i));
         if (r) check("addr", ibus_addr_o, pc_i);
         check("valid", 32'(inst_valid_o), 32'(mq.size() > 0));
         if (mq.size() > 0) begin
            check("inst",  inst_o,      mq[0].inst);
            check("iaddr", inst_addr_o, mq[0].addr);
         end
         check("err", 32'(fetch_err_o), 32'(m_err));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      pc_i = m_next_pc;
      ibus_rdata_i = $urandom;
   endtask

   int          pcc_cnt = 0;
   int          rmode = 60;
   int          rst_hold = 0;
   logic [31:0] tmp;

   initial begin
      repeat (3) tick();
      rst = 1'b1;
      br_target = 32'h100;

      // Directed prologue: boot, streaming, stall, branch kill, timeout, reset in WAIT.
      for (int k = 0; k <= 49; k++) begin
         stalled       = (k >= 11 && k <= 15) ? 6'b000010 : 6'b000000;
         branch_flag_i = (k == 17);
         ibus_gnt_i    = !(k >= 37 && k <= 39);
         if (k >= 21 && k <= 37)      ibus_rvalid_i = 1'b0;
         else if (k == 38)            ibus_rvalid_i = 1'b1;
         else if (k >= 43 && k <= 45) ibus_rvalid_i = 1'b1;
         else                         ibus_rvalid_i = m_last_grant;
         if (k == 43) rst = 1'b0;
         if (k == 45) rst = 1'b1;
         #2;
         if (k < 10) pcc_cnt += int'(pc_change_en_o);
         case (k)
            3:  check("boot_req3", 32'(ibus_req_o), 32'd0);
            4: begin
               check("first_req",  32'(ibus_req_o),     32'd1);
               check("first_addr", ibus_addr_o,         32'h0);
               check("first_pcc",  32'(pc_change_en_o), 32'd1);
            end
            6:  check("seq_addr0", inst_addr_o, 32'h0);
            8:  check("seq_addr4", inst_addr_o, 32'h4);
            10: begin
               check("seq_valid8", 32'(inst_valid_o), 32'd1);
               check("seq_addr8",  inst_addr_o,       32'h8);
            end
            12, 13, 14, 15: begin
               check("stall_noreq", 32'(ibus_req_o),   32'd0);
               check("stall_valid", 32'(inst_valid_o), 32'd1);
               check("stall_iaddr", inst_addr_o,       32'hC);
            end
            16: check("resume_addr", ibus_addr_o, 32'h10);
            18: begin
               check("br_req",   32'(ibus_req_o),   32'd1);
               check("br_addr",  ibus_addr_o,       32'h100);
               check("br_valid", 32'(inst_valid_o), 32'd0);
            end
            19: check("br_valid19", 32'(inst_valid_o), 32'd0);
            20: check("br_target_word", inst_addr_o, 32'h100);
            36: check("to_err_before", 32'(fetch_err_o), 32'd0);
            37: begin
               check("to_err", 32'(fetch_err_o), 32'd1);
               check("to_req", 32'(ibus_req_o),  32'd1);
            end
            39: begin
               check("late_drop", 32'(inst_valid_o), 32'd0);
               check("err_sticky", 32'(fetch_err_o), 32'd1);
            end
            42: check("after_to_word", inst_addr_o, 32'h108);
            43: begin
               check("arst_req",   32'(ibus_req_o),   32'd0);
               check("arst_valid", 32'(inst_valid_o), 32'd0);
               check("arst_inst",  inst_o,            32'd0);
               check("arst_err",   32'(fetch_err_o),  32'd0);
            end
            46, 47, 48: check("reboot_noreq", 32'(ibus_req_o), 32'd0);
            49: begin
               check("reboot_req",  32'(ibus_req_o), 32'd1);
               check("reboot_addr", ibus_addr_o,     32'h0);
            end
            default: ;
         endcase
         tick();
      end
      check("pcc_pulses", 32'(pcc_cnt), 32'd3);

      // Randomized traffic; response probability cycles through fast, slow and silent.
      for (int n = 0; n < 4000; n++) begin
         if (n % 500 == 0) rmode = (n % 1500 == 1000) ? 0 : ((n % 1500 == 500) ? 30 : 60);
         ibus_gnt_i    = ($urandom_range(0, 3) != 0);
         tmp           = $urandom;
         stalled       = {tmp[5:2], ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0)};
         branch_flag_i = ($urandom_range(0, 19) == 0);
         tmp           = $urandom;
         br_target     = {tmp[31:2], 2'b00};
         ibus_rvalid_i = m_out ? ($urandom_range(0, 99) < rmode) : ($urandom_range(0, 29) == 0);
         if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) rst = 1'b1;
         end else if ($urandom_range(0, 399) == 0) begin
            rst = 1'b0;
            rst_hold = 2;
         end
         tick();
      end
      rst = 1'b1;
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
